// File: rtl/interrupt_controller.sv
// Latches edge-triggered peripheral requests, applies mask and fixed priority, and issues one
// interrupt pulse at a time; further issues are held off until the handler's RET retires it.
module interrupt_controller #(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [23:0]        ins,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  output logic               interrupt,
  output logic [2:0]         irq_id,
  output logic               in_service,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask
);

  typedef enum logic [1:0] {IDLE, ISSUE, GUARD, SERVICE} state_t;

  localparam logic [4:0] OP_JMP = 5'b11000;
  localparam logic [4:0] OP_RET = 5'b10000;
  localparam logic [4:0] OP_JC  = 5'b11100;
  localparam logic [4:0] OP_JNC = 5'b11101;
  localparam logic [4:0] OP_JZ  = 5'b11110;
  localparam logic [4:0] OP_JNZ = 5'b11111;

  state_t             state, state_next;
  logic [NUM_IRQ-1:0] irq_prev;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] clr;
  logic [2:0]         winner;
  logic [4:0]         opcode;
  logic               is_ret;
  logic               blocked;
  logic               issue;
  logic               unused_ins;

  assign opcode     = ins[23:19];
  assign unused_ins = ^ins[18:0];
  assign is_ret     = (opcode == OP_RET);
  // Never issue alongside a redirect, or the saved return address would be wrong.
  assign blocked    = (opcode == OP_JMP) || is_ret || (opcode == OP_JC) ||
                      (opcode == OP_JNC) || (opcode == OP_JZ) || (opcode == OP_JNZ);
  assign rise       = irq_in & ~irq_prev;
  assign eligible   = pending & mask;

  always_comb begin
    winner = 3'd0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (eligible[k]) winner = 3'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (issue)  state_next = ISSUE;
      ISSUE:               state_next = GUARD;
      GUARD:               state_next = SERVICE;
      SERVICE: if (is_ret) state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  always_comb begin
    issue      = (state == IDLE) && (|eligible) && !blocked;
    clr        = issue ? (NUM_IRQ'(1) << winner) : '0;
    interrupt  = (state == ISSUE);
    in_service = (state != IDLE);
  end

  // irq_prev tracks irq_in even in reset so a line held high across release is not an edge.
  always_ff @(posedge clk) begin
    irq_prev <= irq_in;
    if (reset) begin
      pending <= '0;
      mask    <= '0;
      irq_id  <= 3'd0;
    end else begin
      pending <= (pending & ~clr) | rise;
      if (mask_we) mask <= mask_wdata;
      if (issue) irq_id <= winner;
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench: stimulus pushes expected interrupt pulses (cycle, id) into a queue that an
// independent monitor pops and compares; status outputs are checked inline.
module tb_interrupt_controller;

  localparam logic [23:0] NOP = 24'h000000;
  localparam logic [23:0] RET = 24'h800000;
  localparam logic [23:0] JMP = 24'hC00005;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq_in;
  logic [23:0] ins;
  logic        mask_we;
  logic [3:0]  mask_wdata;
  logic        interrupt;
  logic [2:0]  irq_id;
  logic        in_service;
  logic [3:0]  pending;
  logic [3:0]  mask;

  typedef struct {
    int         cyc;
    logic [2:0] id;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  interrupt_controller #(.NUM_IRQ(4)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .ins(ins),
    .mask_we(mask_we), .mask_wdata(mask_wdata),
    .interrupt(interrupt), .irq_id(irq_id), .in_service(in_service),
    .pending(pending), .mask(mask)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every interrupt pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (q.size() > 0 && cyc > q[0].cyc) begin
      tests++;
      fails++;
      $display("FAIL missed_irq: got none expected id %0d at cycle %0d", q[0].id, q[0].cyc);
      void'(q.pop_front());
    end
    if (interrupt) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_irq: got id %0d at cycle %0d expected no pulse", irq_id, cyc);
      end else begin
        if (cyc != q[0].cyc || irq_id != q[0].id) begin
          fails++;
          $display("FAIL irq_pulse: got id %0d at cycle %0d expected id %0d at cycle %0d",
                   irq_id, cyc, q[0].id, q[0].cyc);
        end
        void'(q.pop_front());
      end
    end
  end

  task automatic wr_mask(input logic [3:0] m);
    mask_we = 1'b1;
    mask_wdata = m;
    @(negedge clk);
    mask_we = 1'b0;
  endtask

  task automatic ret_seq();
    ins = RET;
    @(negedge clk);
    ins = NOP;
  endtask

  initial begin
    reset = 1'b1; irq_in = 4'b0; ins = NOP; mask_we = 1'b0; mask_wdata = 4'b0;
    repeat (2) @(negedge clk);
    chk("rst_interrupt", 32'(interrupt), 0);
    chk("rst_irq_id", 32'(irq_id), 0);
    chk("rst_in_service", 32'(in_service), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_mask", 32'(mask), 0);
    reset = 1'b0;
    @(negedge clk);

    // Single request on source 2.
    wr_mask(4'b1111);
    chk("mask_write", 32'(mask), 32'hf);
    irq_in = 4'b0100; q.push_back('{cyc + 2, 3'd2});
    @(negedge clk); irq_in = 4'b0;
    chk("t1_pending", 32'(pending), 32'h4);
    chk("t1_no_irq_yet", 32'(interrupt), 0);
    @(negedge clk);
    chk("t1_pending_clr", 32'(pending), 0);
    chk("t1_in_service", 32'(in_service), 1);
    chk("t1_irq_id", 32'(irq_id), 2);
    repeat (3) @(negedge clk);
    chk("t1_svc_hold", 32'(in_service), 1);
    ret_seq();
    chk("t1_retired", 32'(in_service), 0);

    // Simultaneous sources 3 and 1: lowest index first, then 3 two cycles after RET.
    irq_in = 4'b1010; q.push_back('{cyc + 2, 3'd1});
    @(negedge clk); irq_in = 4'b0;
    chk("t2_pending", 32'(pending), 32'ha);
    @(negedge clk);
    chk("t2_pending_left", 32'(pending), 32'h8);
    repeat (2) @(negedge clk);
    q.push_back('{cyc + 2, 3'd3});
    ret_seq();
    chk("t2_gap_idle", 32'(in_service), 0);
    @(negedge clk);
    chk("t2_second_id", 32'(irq_id), 3);
    repeat (2) @(negedge clk);
    ret_seq();

    // Masked source latches but does not issue until enabled.
    wr_mask(4'b0000);
    chk("t3_mask_zero", 32'(mask), 0);
    irq_in = 4'b0001;
    @(negedge clk); irq_in = 4'b0;
    chk("t3_pending_masked", 32'(pending), 32'h1);
    repeat (3) @(negedge clk);
    chk("t3_still_pending", 32'(pending), 32'h1);
    q.push_back('{cyc + 2, 3'd0});
    wr_mask(4'b0001);
    @(negedge clk);
    chk("t3_irq_id", 32'(irq_id), 0);
    chk("t3_pending_clr", 32'(pending), 0);
    repeat (2) @(negedge clk);
    ret_seq();
    wr_mask(4'b1111);

    // JMP held for three cycles with a request pending blocks issue.
    ins = JMP; irq_in = 4'b0010;
    @(negedge clk); irq_in = 4'b0;
    chk("t4_pending", 32'(pending), 32'h2);
    repeat (3) begin
      @(negedge clk);
      chk("t4_blocked", 32'(in_service), 0);
    end
    ins = NOP; q.push_back('{cyc + 1, 3'd1});
    @(negedge clk);
    chk("t4_issued", 32'(in_service), 1);
    repeat (2) @(negedge clk);

    // Two rises on source 1 during service collapse into one pending request.
    irq_in = 4'b0010; @(negedge clk);
    irq_in = 4'b0000; @(negedge clk);
    irq_in = 4'b0010; @(negedge clk);
    irq_in = 4'b0000; @(negedge clk);
    chk("t5_pending", 32'(pending), 32'h2);
    chk("t5_in_service", 32'(in_service), 1);
    q.push_back('{cyc + 2, 3'd1});
    ret_seq();
    repeat (3) @(negedge clk);
    ret_seq();
    repeat (4) @(negedge clk);
    chk("t5_pending_drained", 32'(pending), 0);
    chk("t5_idle", 32'(in_service), 0);

    // Line held high across reset release produces no edge.
    reset = 1'b1; irq_in = 4'b0001;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_no_pending", 32'(pending), 0);
    wr_mask(4'b1111);
    repeat (3) @(negedge clk);
    chk("t6_no_pending_unmasked", 32'(pending), 0);
    chk("t6_no_service", 32'(in_service), 0);
    irq_in = 4'b0;
    @(negedge clk);

    // Reset during SERVICE drops everything.
    irq_in = 4'b0100; q.push_back('{cyc + 2, 3'd2});
    @(negedge clk); irq_in = 4'b0;
    repeat (3) @(negedge clk);
    irq_in = 4'b1000;
    @(negedge clk); irq_in = 4'b0;
    chk("t7_pending_pre", 32'(pending), 32'h8);
    chk("t7_svc_pre", 32'(in_service), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("t7_in_service", 32'(in_service), 0);
    chk("t7_pending", 32'(pending), 0);
    chk("t7_mask", 32'(mask), 0);
    chk("t7_irq_id", 32'(irq_id), 0);
    chk("t7_interrupt", 32'(interrupt), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
